lsu_dmem_master: RTL and testbench
==================================

// Module: lsu_dmem_master
// PURPOSE
//  CPU-side load/store initiator for the multi-cycle data memory. Accepts one
//  load/store from the MEM stage and runs the dmem mem_read/mem_write/mem_ready
//  handshake. Performs byte/half extraction with sign or zero extension.
//  Implements sub-word stores as read-modify-write, and sends MMIO byte stores directly.
// PARAMETERS
//  MMIO_ADDR  32'h1000_0000  console address; byte/half/word store here skips RMW
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, asynchronous, active-high
//  req_valid     in   1   CPU request valid
//  req_ready     out  1   high only in IDLE; request accepted when valid&ready
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   0=byte, 1=half, 2=word, 3=illegal (treated as misaligned)
//  req_unsigned  in   1   loads: 1=zero-extend, 0=sign-extend
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, right-aligned
//  resp_valid    out  1   one-cycle pulse: access done
//  resp_rdata    out  32  extended load data; 0 for stores and errors
//  resp_err      out  1   misaligned/illegal size; valid with resp_valid
//  mem_addr      out  32  to dmem: {req_addr[31:2],2'b00}, or MMIO_ADDR exactly
//  mem_wdata     out  32  to dmem write data
//  mem_read      out  1   to dmem, registered, one-cycle pulse
//  mem_write     out  1   to dmem, registered, one-cycle pulse
//  mem_rdata     in   32  from dmem, valid when mem_ready rises after issue
//  mem_ready     in   1   from dmem; 1 when idle, 0 while busy
// BEHAVIOUR
//  Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//   mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0. Reset mid-access aborts.
//   dmem shares rst, so no orphan transaction remains.
//  States:
//   IDLE: on accept, latch we/size/unsigned/addr/wdata.
//    Misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=3):
//     next cycle resp_valid=1, resp_err=1; stays in IDLE; no dmem access.
//    Load or sub-word non-MMIO store -> RD_ISSUE.
//    Word store, or any store to MMIO_ADDR -> WR_ISSUE.
//   RD_ISSUE: mem_read=1 for exactly this cycle -> RD_WAIT.
//   RD_WAIT: mem_read=0; hold mem_addr. On mem_ready=1, capture mem_rdata.
//    Load: goto IDLE and pulse resp_valid with extended data.
//    Store: merge lanes and goto WR_ISSUE.
//   WR_ISSUE: mem_write=1 for exactly this cycle -> WR_WAIT.
//   WR_WAIT: hold mem_addr/mem_wdata. On mem_ready=1 goto IDLE and pulse
//    resp_valid with rdata=0.
//  mem_ready=1 during an ISSUE cycle (dmem is still idle) is never treated as completion.
//   mem_read/mem_write must be low when mem_ready returns; otherwise dmem re-issues.
//  Lanes: byte lane = addr[1:0]*8; half lane = addr[1]*16.
//   Store merge replaces only the selected lane of the read word.
//   MMIO store: mem_wdata = req_wdata as given, with no shift.
//  Load extend: byte -> bit 7, half -> bit 15, unless req_unsigned=1.
//  resp_valid and the IDLE return are set on the same edge, so req_ready=1 in
//   the resp_valid cycle and a back-to-back accept is allowed.
//  req_valid while req_ready=0 is ignored; the CPU must hold it (MEM stage stall).
//  Latency (dmem 3-cycle delay), measured from the accept cycle T:
//   load/word store resp_valid at T+6; RMW store at T+11; error at T+1.
// TESTING
//  1) mem[0x40]=0x8899AABB; LB addr 0x103, signed -> resp_rdata=0xFFFFFF88 at T+6;
//     LBU gives 0x00000088.
//  2) SW 0x200 data 0xDEADBEEF -> exactly one mem_write pulse; mem[0x80]=0xDEADBEEF;
//     resp_valid at T+6.
//  3) mem[0x80]=0x11223344; SH 0x202 data 0xABCD -> one read then one write;
//     word becomes 0xABCD3344; LHU 0x202 returns 0x0000ABCD.
//  4) SB to 0x10000000 data 0x41 -> no mem_read; mem_wdata=0x41; console prints 'A'.
//  5) LW 0x201 -> resp_err=1 at T+1; mem_read/mem_write never asserted.
//  6) Back-to-back LW/SW with req_valid held -> second accept in the first
//     resp_valid cycle; rst mid-RD_WAIT -> all outputs return to reset values.

Source files
------------

// File: rtl/lsu_dmem_master.sv
// CPU-side load/store initiator for the multi-cycle data memory.
// Sub-word stores are read-modify-write. Stores to the console address are written directly.
module lsu_dmem_master #(
    parameter logic [31:0] MMIO_ADDR = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_WR_ISSUE,
        S_WR_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic [15:0] wdata_q, wdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    logic        misaligned;
    logic        is_mmio;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign misaligned = (req_size == 2'd3)
                     || ((req_size == 2'd1) && req_addr[0])
                     || ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
    assign is_mmio    = (req_addr == MMIO_ADDR);

    // Lane extraction and merge both work on the word the dmem just returned.
    always_comb begin
        byte_sel = 8'h00;
        case (addr_lo_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (size_q)
            2'd0:    load_ext = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'd1:    load_ext = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase

        merged = mem_rdata;
        if (size_q == 2'd0) begin
            case (addr_lo_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_lo_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d      = req_we;
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    addr_lo_d = req_addr[1:0];
                    wdata_d   = req_wdata[15:0];
                    if (misaligned) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we && ((req_size == 2'd2) || is_mmio)) begin
                        state_d     = S_WR_ISSUE;
                        mem_write_d = 1'b1;
                        mem_addr_d  = is_mmio ? MMIO_ADDR : {req_addr[31:2], 2'b00};
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = S_RD_ISSUE;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_addr[31:2], 2'b00};
                    end
                end
            end
            // mem_ready is still high from the idle dmem here; only WAIT states look at it.
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (mem_ready) begin
                    if (we_q) begin
                        state_d     = S_WR_ISSUE;
                        mem_write_d = 1'b1;
                        mem_wdata_d = merged;
                    end else begin
                        state_d      = S_IDLE;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = load_ext;
                    end
                end
            end
            S_WR_ISSUE: state_d = S_WR_WAIT;
            S_WR_WAIT: begin
                if (mem_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            addr_lo_q    <= 2'd0;
            wdata_q      <= 16'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Directed bench for lsu_dmem_master against a 3-cycle dmem model with a console word.
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    lsu_dmem_master dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    // dmem model: ready drops for 3 cycles after an issue, then completes.
    logic [31:0] mem [0:255];
    int          dm_cnt;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] con_data = 32'h0;
    int          con_cnt = 0;
    int          rd_pulses = 0;
    int          wr_pulses = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ready <= 1'b1;
            mem_rdata <= 32'h0;
            dm_cnt    <= 0;
            dm_we     <= 1'b0;
            dm_addr   <= 32'h0;
            dm_wdata  <= 32'h0;
        end else if (dm_cnt != 0) begin
            if (dm_cnt == 1) begin
                mem_ready <= 1'b1;
                if (!dm_we) begin
                    mem_rdata <= mem[dm_addr[9:2]];
                end else if (dm_addr == 32'h1000_0000) begin
                    con_data <= dm_wdata;
                    con_cnt  <= con_cnt + 1;
                end else begin
                    mem[dm_addr[9:2]] <= dm_wdata;
                end
            end
            dm_cnt <= dm_cnt - 1;
        end else if (mem_ready && (mem_read || mem_write)) begin
            mem_ready <= 1'b0;
            dm_cnt    <= 3;
            dm_we     <= mem_write;
            dm_addr   <= mem_addr;
            dm_wdata  <= mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (mem_read)  rd_pulses <= rd_pulses + 1;
        if (mem_write) wr_pulses <= wr_pulses + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    // Drives one request at a negedge, accepts it on the next posedge, and
    // measures the resp_valid latency in cycles (-1 on timeout).
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat   = n;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        $display("txn we=%0d size=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, size, uns, addr, wdata, rdata, err, lat);
    endtask

    vec_t        vecs[$];
    logic [31:0] got_rdata;
    logic        got_err;
    int          got_lat;
    int          rd0, wr0;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;

        vecs.push_back('{1, 2, 0, 32'h100, 32'h8899AABB, 32'h0, 0, 6, 0, 1});
        vecs.push_back('{0, 0, 0, 32'h103, 32'h0, 32'hFFFFFF88, 0, 6, 1, 0});
        vecs.push_back('{0, 0, 1, 32'h103, 32'h0, 32'h00000088, 0, 6, 1, 0});
        vecs.push_back('{0, 0, 0, 32'h100, 32'h0, 32'hFFFFFFBB, 0, 6, 1, 0});
        vecs.push_back('{0, 0, 1, 32'h101, 32'h0, 32'h000000AA, 0, 6, 1, 0});
        vecs.push_back('{0, 1, 0, 32'h100, 32'h0, 32'hFFFFAABB, 0, 6, 1, 0});
        vecs.push_back('{0, 1, 1, 32'h102, 32'h0, 32'h00008899, 0, 6, 1, 0});
        vecs.push_back('{0, 1, 0, 32'h102, 32'h0, 32'hFFFF8899, 0, 6, 1, 0});
        vecs.push_back('{0, 2, 0, 32'h100, 32'h0, 32'h8899AABB, 0, 6, 1, 0});
        vecs.push_back('{1, 2, 0, 32'h200, 32'hDEADBEEF, 32'h0, 0, 6, 0, 1});
        vecs.push_back('{0, 2, 0, 32'h200, 32'h0, 32'hDEADBEEF, 0, 6, 1, 0});
        vecs.push_back('{1, 2, 0, 32'h200, 32'h11223344, 32'h0, 0, 6, 0, 1});
        vecs.push_back('{1, 1, 0, 32'h202, 32'h0000ABCD, 32'h0, 0, 11, 1, 1});
        vecs.push_back('{0, 2, 0, 32'h200, 32'h0, 32'hABCD3344, 0, 6, 1, 0});
        vecs.push_back('{0, 1, 1, 32'h202, 32'h0, 32'h0000ABCD, 0, 6, 1, 0});
        vecs.push_back('{1, 0, 0, 32'h201, 32'hFFFFFF55, 32'h0, 0, 11, 1, 1});
        vecs.push_back('{0, 2, 0, 32'h200, 32'h0, 32'hABCD5544, 0, 6, 1, 0});
        vecs.push_back('{1, 1, 0, 32'h200, 32'h12347777, 32'h0, 0, 11, 1, 1});
        vecs.push_back('{0, 2, 0, 32'h200, 32'h0, 32'hABCD7777, 0, 6, 1, 0});
        vecs.push_back('{0, 1, 0, 32'h200, 32'h0, 32'h00007777, 0, 6, 1, 0});
        vecs.push_back('{1, 0, 0, 32'h10000000, 32'h00000041, 32'h0, 0, 6, 0, 1});
        vecs.push_back('{0, 2, 0, 32'h201, 32'h0, 32'h0, 1, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h203, 32'h0, 32'h0, 1, 1, 0, 0});
        vecs.push_back('{1, 2, 0, 32'h202, 32'h12345678, 32'h0, 1, 1, 0, 0});
        vecs.push_back('{0, 3, 0, 32'h200, 32'h0, 32'h0, 1, 1, 0, 0});

        // Reset values while rst is held
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", {31'h0, resp_err}, 32'h0);
        chk("rst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            rd0 = rd_pulses;
            wr0 = wr_pulses;
            do_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                   got_rdata, got_err, got_lat);
            chk($sformatf("v%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_err", i), {31'h0, got_err}, {31'h0, vecs[i].exp_err});
            chk($sformatf("v%0d_latency", i), got_lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_reads", i), rd_pulses - rd0, vecs[i].exp_rd);
            chk($sformatf("v%0d_writes", i), wr_pulses - wr0, vecs[i].exp_wr);
        end

        // Console store and model-side memory contents
        chk("console_data", con_data, 32'h00000041);
        chk("console_count", con_cnt, 1);
        chk("mem_word_0x100", mem[8'h40], 32'h8899AABB);
        chk("mem_word_0x200", mem[8'h80], 32'hABCD7777);

        // Back-to-back: LW then SW with req_valid held across the response cycle
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h100; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_we = 1'b1; req_addr = 32'h300; req_wdata = 32'hCAFEF00D;
        got_lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                got_lat = n;
                break;
            end
        end
        chk("b2b_first_latency", got_lat, 6);
        chk("b2b_first_rdata", resp_rdata, 32'h8899AABB);
        chk("b2b_ready_in_resp", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        got_lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                got_lat = n;
                break;
            end
        end
        $display("txn back-to-back LW 0x100 / SW 0x300 -> second lat=%0d", got_lat);
        chk("b2b_second_latency", got_lat, 6);
        chk("b2b_reads", rd_pulses - rd0, 1);
        chk("b2b_writes", wr_pulses - wr0, 1);
        do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, got_rdata, got_err, got_lat);
        chk("b2b_readback", got_rdata, 32'hCAFEF00D);

        // Reset in the middle of RD_WAIT
        rd0 = rd_pulses;
        wr0 = wr_pulses;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'h301;
        req_wdata = 32'h99;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        chk("midrst_resp", {30'h0, resp_valid, resp_err}, 32'h0);
        chk("midrst_resp_rdata", resp_rdata, 32'h0);
        chk("midrst_mem_rw", {30'h0, mem_read, mem_write}, 32'h0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        got_lat = 0;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (resp_valid) got_lat++;
        end
        $display("txn SB 0x301 aborted by reset -> stray resp=%0d", got_lat);
        chk("midrst_no_resp", got_lat, 0);
        chk("midrst_reads", rd_pulses - rd0, 1);
        chk("midrst_writes", wr_pulses - wr0, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, got_rdata, got_err, got_lat);
        chk("post_rst_readback", got_rdata, 32'hCAFEF00D);
        chk("post_rst_latency", got_lat, 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
